// File: rtl/col_sense_if.sv
// Array-side bus of the column sense sequencer: control request in,
// bit-line / match-line samples in, strobes and captured results out.
interface col_sense_if #(
    parameter int COLS = 8,
    parameter int ROWS = 8,
    parameter int AW   = 3
);
    logic            start;
    logic            mode;
    logic [COLS-1:0] BL;
    logic [COLS-1:0] BLB;
    logic [ROWS-1:0] ML;
    logic            pre_en;
    logic            sa_en;
    logic            busy;
    logic            valid;
    logic [COLS-1:0] rdata;
    logic [COLS-1:0] err;
    logic            hit;
    logic [AW-1:0]   hit_addr;
    logic            multi_hit;

    modport master (
        output start, mode, BL, BLB, ML,
        input  pre_en, sa_en, busy, valid, rdata, err, hit, hit_addr, multi_hit
    );

    modport slave (
        input  start, mode, BL, BLB, ML,
        output pre_en, sa_en, busy, valid, rdata, err, hit, hit_addr, multi_hit
    );
endinterface

// File: rtl/col_sense.sv
// Column sense/readout sequencer: precharge -> develop -> sense, then resolve
// BL/BLB into a read word or the match-lines into a priority-encoded hit.
module col_sense #(
    parameter int COLS    = 8,
    parameter int ROWS    = 8,
    parameter int AW      = 3,
    parameter int DEV_CYC = 2
) (
    input logic        clk,
    input logic        rst,
    col_sense_if.slave bus
);
    localparam int         PCW      = $clog2(ROWS + 1);
    localparam logic [3:0] DEV_LOAD = 4'(DEV_CYC - 1);

    typedef enum logic [2:0] {IDLE, PRE, DEV, SENSE, DONE} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic            pre_en_q, sa_en_q, busy_q, valid_q;
    logic [COLS-1:0] rdata_q, rdata_d, err_q, err_d;
    logic            hit_q, hit_d, multi_q, multi_d;
    logic [AW-1:0]   addr_q, addr_d;

    logic [COLS-1:0] col_rd, col_err;
    logic [AW-1:0]   lo_addr;
    logic [PCW-1:0]  ml_ones;

    // Per-column differential resolve; an equal pair is flagged, never trusted.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign col_rd[c]  = bus.BL[c] & ~bus.BLB[c];
        assign col_err[c] = ~(bus.BL[c] ^ bus.BLB[c]);
    end

    always_comb begin
        lo_addr = '0;
        ml_ones = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (bus.ML[i]) lo_addr = AW'(i);
        end
        for (int i = 0; i < ROWS; i++) begin
            ml_ones = ml_ones + PCW'(bus.ML[i]);
        end
    end

    // DONE's exit edge doubles as the IDLE sampling edge, so a held start
    // sustains one op every DEV_CYC+3 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = PRE;
                    mode_d  = bus.mode;
                end
            end
            PRE: begin
                state_d = DEV;
                cnt_d   = DEV_LOAD;
            end
            DEV: begin
                if (cnt_q == 4'd0) state_d = SENSE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            SENSE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        hit_d   = hit_q;
        addr_d  = addr_q;
        multi_d = multi_q;
        if (state_q == SENSE) begin
            if (mode_q) begin
                rdata_d = col_rd;
                err_d   = col_err;
            end else begin
                hit_d   = |bus.ML;
                addr_d  = lo_addr;
                multi_d = (ml_ones >= PCW'(2));
            end
        end
    end

    // Strobes are decoded from the next state so they come straight off flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            pre_en_q <= 1'b0;
            sa_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            rdata_q  <= '0;
            err_q    <= '0;
            hit_q    <= 1'b0;
            addr_q   <= '0;
            multi_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            pre_en_q <= (state_d == PRE);
            sa_en_q  <= (state_d == SENSE);
            busy_q   <= (state_d != IDLE);
            valid_q  <= (state_d == DONE);
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            hit_q    <= hit_d;
            addr_q   <= addr_d;
            multi_q  <= multi_d;
        end
    end

    assign bus.pre_en    = pre_en_q;
    assign bus.sa_en     = sa_en_q;
    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign bus.hit       = hit_q;
    assign bus.hit_addr  = addr_q;
    assign bus.multi_hit = multi_q;
endmodule

// File: tb/tb_col_sense.sv
// Self-checking bench for col_sense: randomized ops against a rule-level model,
// with a second instance at DEV_CYC=1 for the short-latency case.
`timescale 1ns/1ps
module tb_col_sense;
    localparam int DC = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] m_rdata, m_err, m1_rdata;
    logic       m_hit, m_multi;
    logic [2:0] m_addr;

    always #5 clk = ~clk;

    col_sense_if #(.COLS(8), .ROWS(8), .AW(3)) if2 ();
    col_sense_if #(.COLS(8), .ROWS(8), .AW(3)) if1 ();

    col_sense #(.COLS(8), .ROWS(8), .AW(3), .DEV_CYC(DC)) dut (
        .clk(clk), .rst(rst), .bus(if2)
    );
    col_sense #(.COLS(8), .ROWS(8), .AW(3), .DEV_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: per-column rule table for reads, lowest-set-row search for CAM.
    function automatic void model_op(input logic md, input logic [7:0] bl, blb, ml);
        if (md) begin
            for (int c = 0; c < 8; c++) begin
                if (bl[c] == 1'b1 && blb[c] == 1'b0)      begin m_rdata[c] = 1'b1; m_err[c] = 1'b0; end
                else if (bl[c] == 1'b0 && blb[c] == 1'b1) begin m_rdata[c] = 1'b0; m_err[c] = 1'b0; end
                else                                      begin m_rdata[c] = 1'b0; m_err[c] = 1'b1; end
            end
        end else begin
            m_hit   = (ml != 8'd0);
            m_multi = ($countones(ml) >= 2);
            m_addr  = 3'd0;
            for (int i = 7; i >= 0; i--) if (ml[i]) m_addr = 3'(i);
        end
    endfunction

    // One op on the DEV_CYC=2 instance; with junk set, inputs/mode/start are
    // scrambled until the sense cycle, where the real values are presented.
    task automatic run_op(input logic md, input logic [7:0] bl, blb, ml, input bit junk);
        logic [20:0] got, exp;
        if2.start = 1'b1; if2.mode = md;
        if2.BL = junk ? 8'($urandom) : bl;
        if2.BLB = junk ? 8'($urandom) : blb;
        if2.ML = junk ? 8'($urandom) : ml;
        tick();
        for (int j = 0; j <= DC + 3; j++) begin
            if (j == DC + 2) model_op(md, bl, blb, ml);
            checks += 5;
            if (if2.pre_en !== (j == 0)) begin failures++; $display("FAIL op_pre_en j=%0d got=%b want=%b", j, if2.pre_en, j == 0); end
            if (if2.sa_en !== (j == DC + 1)) begin failures++; $display("FAIL op_sa_en j=%0d got=%b want=%b", j, if2.sa_en, j == DC + 1); end
            if (if2.valid !== (j == DC + 2)) begin failures++; $display("FAIL op_valid j=%0d got=%b want=%b", j, if2.valid, j == DC + 2); end
            if (if2.busy !== (j <= DC + 2)) begin failures++; $display("FAIL op_busy j=%0d got=%b want=%b", j, if2.busy, j <= DC + 2); end
            if ((if2.pre_en & if2.sa_en) !== 1'b0) begin failures++; $display("FAIL op_strobe_overlap j=%0d got=1 want=0", j); end
            got = {if2.rdata, if2.err, if2.hit, if2.hit_addr, if2.multi_hit};
            exp = {m_rdata, m_err, m_hit, m_addr, m_multi};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL op_results j=%0d md=%b got=%h want=%h", j, md, got, exp); end
            if (j < DC + 1) begin
                if2.start = junk ? 1'($urandom) : 1'b0;
                if (junk) begin
                    if2.mode = 1'($urandom); if2.BL = 8'($urandom);
                    if2.BLB = 8'($urandom); if2.ML = 8'($urandom);
                end
            end else begin
                if2.start = 1'b0; if2.BL = bl; if2.BLB = blb; if2.ML = ml;
                if (junk) if2.mode = 1'($urandom);
            end
            if (j < DC + 3) tick();
        end
        if2.BL = 8'($urandom); if2.BLB = 8'($urandom); if2.ML = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({if2.pre_en, if2.sa_en, if2.busy, if2.valid, if2.rdata, if2.err, if2.hit, if2.hit_addr, if2.multi_hit} !== 25'd0) begin
            failures++; $display("FAIL reset_outputs got=%h want=0",
                {if2.pre_en, if2.sa_en, if2.busy, if2.valid, if2.rdata, if2.err, if2.hit, if2.hit_addr, if2.multi_hit});
        end
        tick();
        rst = 1'b0;
        m_rdata = '0; m_err = '0; m_hit = 1'b0; m_addr = '0; m_multi = 1'b0;
        run_op(1'b1, 8'hA5, 8'h5A, 8'h00, 1'b0);
        checks++;
        if ({if2.rdata, if2.err} !== {8'hA5, 8'h00}) begin
            failures++; $display("FAIL first_read got=%h/%h want=a5/00", if2.rdata, if2.err);
        end
    endtask

    task automatic test_invalid_diff();
        run_op(1'b0, 8'h00, 8'h00, 8'b0010_0100, 1'b0);
        run_op(1'b1, 8'hF0, 8'hC0, 8'hFF, 1'b0);
        checks++;
        if ({if2.rdata, if2.err} !== {8'h30, 8'hCF}) begin
            failures++; $display("FAIL invalid_diff got=%h/%h want=30/cf", if2.rdata, if2.err);
        end
        checks++;
        if ({if2.hit, if2.hit_addr, if2.multi_hit} !== {1'b1, 3'd2, 1'b1}) begin
            failures++; $display("FAIL invalid_diff_hold got=%b/%0d/%b want=1/2/1", if2.hit, if2.hit_addr, if2.multi_hit);
        end
    endtask

    task automatic test_search();
        run_op(1'b0, 8'h12, 8'h34, 8'b0010_1000, 1'b0);
        checks++;
        if ({if2.hit, if2.hit_addr, if2.multi_hit} !== {1'b1, 3'd3, 1'b1}) begin
            failures++; $display("FAIL search_28 got=%b/%0d/%b want=1/3/1", if2.hit, if2.hit_addr, if2.multi_hit);
        end
        run_op(1'b0, 8'h56, 8'h78, 8'h80, 1'b0);
        checks++;
        if ({if2.hit, if2.hit_addr, if2.multi_hit} !== {1'b1, 3'd7, 1'b0}) begin
            failures++; $display("FAIL search_80 got=%b/%0d/%b want=1/7/0", if2.hit, if2.hit_addr, if2.multi_hit);
        end
        run_op(1'b0, 8'h9A, 8'hBC, 8'h00, 1'b0);
        checks++;
        if ({if2.hit, if2.hit_addr, if2.multi_hit} !== {1'b0, 3'd0, 1'b0}) begin
            failures++; $display("FAIL search_00 got=%b/%0d/%b want=0/0/0", if2.hit, if2.hit_addr, if2.multi_hit);
        end
        checks++;
        if ({if2.rdata, if2.err} !== {8'h30, 8'hCF}) begin
            failures++; $display("FAIL search_rdata_hold got=%h/%h want=30/cf", if2.rdata, if2.err);
        end
    endtask

    task automatic test_sample_point();
        for (int n = 0; n < 12; n++)
            run_op(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    endtask

    task automatic test_midop_reset();
        if2.start = 1'b1; if2.mode = 1'b1; if2.BL = 8'hFF; if2.BLB = 8'h00;
        tick();
        if2.start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({if2.pre_en, if2.sa_en, if2.busy, if2.valid, if2.rdata, if2.err, if2.hit, if2.hit_addr, if2.multi_hit} !== 25'd0) begin
            failures++; $display("FAIL midop_reset_outputs got=%h want=0",
                {if2.pre_en, if2.sa_en, if2.busy, if2.valid, if2.rdata, if2.err, if2.hit, if2.hit_addr, if2.multi_hit});
        end
        m_rdata = '0; m_err = '0; m_hit = 1'b0; m_addr = '0; m_multi = 1'b0;
        tick();
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            checks++;
            if ({if2.valid, if2.busy} !== 2'b00) begin
                failures++; $display("FAIL midop_no_valid j=%0d got=%b%b want=00", j, if2.valid, if2.busy);
            end
        end
        run_op(1'b0, 8'h00, 8'h00, 8'b0100_0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ml;
        ml = 8'($urandom) | 8'h01;
        if2.start = 1'b1; if2.mode = 1'b0; if2.ML = ml;
        tick();
        for (int j = 0; j < 15; j++) begin
            if (j % 5 == 4) model_op(1'b0, 8'h00, 8'h00, ml);
            checks += 3;
            if (if2.valid !== (j % 5 == 4)) begin failures++; $display("FAIL b2b_valid j=%0d got=%b want=%b", j, if2.valid, j % 5 == 4); end
            if (if2.pre_en !== (j % 5 == 0)) begin failures++; $display("FAIL b2b_pre_en j=%0d got=%b want=%b", j, if2.pre_en, j % 5 == 0); end
            if ({if2.busy, if2.hit, if2.hit_addr, if2.multi_hit} !== {1'b1, m_hit, m_addr, m_multi}) begin
                failures++; $display("FAIL b2b_state j=%0d got=%b/%b/%0d/%b want=1/%b/%0d/%b", j,
                    if2.busy, if2.hit, if2.hit_addr, if2.multi_hit, m_hit, m_addr, m_multi);
            end
            if (j == 14) if2.start = 1'b0;
            tick();
        end
        checks++;
        if (if2.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b want=0", if2.busy); end
    endtask

    task automatic test_dev1();
        logic [7:0] bl, blb;
        bl = 8'($urandom); blb = 8'($urandom);
        for (int c = 0; c < 8; c++) m1_rdata[c] = (bl[c] == 1'b1 && blb[c] == 1'b0);
        if1.start = 1'b1; if1.mode = 1'b1; if1.BL = bl; if1.BLB = blb;
        tick();
        if1.start = 1'b0;
        for (int j = 0; j <= 4; j++) begin
            checks += 3;
            if (if1.pre_en !== (j == 0)) begin failures++; $display("FAIL dev1_pre_en j=%0d got=%b want=%b", j, if1.pre_en, j == 0); end
            if (if1.sa_en !== (j == 2)) begin failures++; $display("FAIL dev1_sa_en j=%0d got=%b want=%b", j, if1.sa_en, j == 2); end
            if (if1.valid !== (j == 3)) begin failures++; $display("FAIL dev1_valid j=%0d got=%b want=%b", j, if1.valid, j == 3); end
            if (j == 3) begin
                checks++;
                if (if1.rdata !== m1_rdata) begin failures++; $display("FAIL dev1_rdata got=%h want=%h", if1.rdata, m1_rdata); end
            end
            if (j < 4) tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        if2.start = 1'b0; if2.mode = 1'b0; if2.BL = '0; if2.BLB = '0; if2.ML = '0;
        if1.start = 1'b0; if1.mode = 1'b0; if1.BL = '0; if1.BLB = '0; if1.ML = '0;
        test_reset();
        test_invalid_diff();
        test_search();
        test_sample_point();
        test_midop_reset();
        test_back_to_back();
        test_dev1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
